conv_output_quantizer: RTL and testbench

Output stage of the convolution datapath, directly downstream of the adder tree. It accepts the full-precision signed convolution result (FULL_SIZE = 2·DATA_SIZE + EXTRA_BITS = 36 bits) and applies a per-sample arithmetic right shift. It then rounds half-up and saturates to a DATA_SIZE-bit (16-bit) signed sample. A 2-stage valid/ready pipeline gives full throughput, and the block keeps a saturation-event counter for gain tuning.

---
 rtl/conv_output_quantizer.sv | 125 ++++++++++++
 tb/tb_conv_output_quantizer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_quantizer.sv
// Output stage of the convolution datapath: per-sample arithmetic right shift,
// round half-up and saturate to a DATA_SIZE-bit sample over a 2-stage valid/ready pipe.
module conv_output_quantizer #(
    parameter int DATA_SIZE   = 16,
    parameter int FULL_SIZE   = 36,
    parameter int SHIFT_WIDTH = 6,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [FULL_SIZE-1:0]   in_data,
    input  logic        [SHIFT_WIDTH-1:0] in_shift,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [DATA_SIZE-1:0]   out_data,
    output logic                          out_sat,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          sat_count_clear,
    output logic        [COUNT_WIDTH-1:0] sat_count
);

    localparam logic [SHIFT_WIDTH-1:0]      MAX_SHIFT = SHIFT_WIDTH'(FULL_SIZE - 1);
    localparam logic signed [FULL_SIZE:0]   SAT_MAX   = (FULL_SIZE+1)'(2**(DATA_SIZE-1) - 1);
    localparam logic signed [FULL_SIZE:0]   SAT_MIN   = -((FULL_SIZE+1)'(2**(DATA_SIZE-1)));
    localparam logic [COUNT_WIDTH-1:0]      COUNT_MAX = '1;

    logic                          valid1_q, valid1_d;
    logic signed [FULL_SIZE-1:0]   sh1_q, sh1_d;
    logic                          rb1_q, rb1_d;
    logic                          valid2_q, valid2_d;
    logic        [DATA_SIZE-1:0]   data2_q, data2_d;
    logic                          sat2_q, sat2_d;
    logic        [COUNT_WIDTH-1:0] count_q, count_d;

    logic                          advance1, advance2;
    logic        [SHIFT_WIDTH-1:0] sEff, rbShift;
    logic signed [FULL_SIZE-1:0]   shifted;
    logic        [FULL_SIZE-1:0]   roundShift;
    logic                          rbNew;
    logic signed [FULL_SIZE:0]     rounded;

    assign advance2 = !valid2_q || out_ready;
    assign advance1 = !valid1_q || advance2;
    assign in_ready = advance1;

    // Shifts past the accumulator width would only replicate the sign, so clamp them.
    assign sEff       = (in_shift > MAX_SHIFT) ? MAX_SHIFT : in_shift;
    assign rbShift    = sEff - 1'b1;
    assign shifted    = in_data >>> sEff;
    assign roundShift = in_data >> rbShift;
    assign rbNew      = (sEff != '0) && roundShift[0];

    always_comb begin
        valid1_d = valid1_q;
        sh1_d    = sh1_q;
        rb1_d    = rb1_q;
        if (advance1) begin
            valid1_d = in_valid;
            if (in_valid) begin
                sh1_d = shifted;
                rb1_d = rbNew;
            end
        end
    end

    // One extra bit keeps the rounding carry from wrapping at the top of the range.
    assign rounded = {sh1_q[FULL_SIZE-1], sh1_q} + {{FULL_SIZE{1'b0}}, rb1_q};

    always_comb begin
        valid2_d = valid2_q;
        data2_d  = data2_q;
        sat2_d   = sat2_q;
        if (advance2) begin
            valid2_d = valid1_q;
            if (valid1_q) begin
                if (rounded > SAT_MAX) begin
                    data2_d = {1'b0, {(DATA_SIZE-1){1'b1}}};
                    sat2_d  = 1'b1;
                end else if (rounded < SAT_MIN) begin
                    data2_d = {1'b1, {(DATA_SIZE-1){1'b0}}};
                    sat2_d  = 1'b1;
                end else begin
                    data2_d = rounded[DATA_SIZE-1:0];
                    sat2_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (sat_count_clear) begin
            count_d = '0;
        end else if (valid2_q && out_ready && sat2_q && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_q <= 1'b0;
            sh1_q    <= '0;
            rb1_q    <= 1'b0;
            valid2_q <= 1'b0;
            data2_q  <= '0;
            sat2_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            valid1_q <= valid1_d;
            sh1_q    <= sh1_d;
            rb1_q    <= rb1_d;
            valid2_q <= valid2_d;
            data2_q  <= data2_d;
            sat2_q   <= sat2_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = valid2_q;
    assign out_data  = data2_q;
    assign out_sat   = sat2_q;
    assign sat_count = count_q;

endmodule

// File: tb/tb_conv_output_quantizer.sv
// Directed bench for conv_output_quantizer: rounding, saturation, shift clamp,
// back-pressure against a reference model, counter limits and mid-stream reset.
module tb_conv_output_quantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [35:0] in_data;
    logic [5:0]  in_shift;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        sat_count_clear;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    logic [16:0] expQ[$];

    conv_output_quantizer dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_shift        (in_shift),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_sat         (out_sat),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sat_count_clear (sat_count_clear),
        .sat_count       (sat_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference quantizer written as floor((v + 2^(s-1)) / 2^s) followed by clipping.
    function automatic logic [16:0] refQuant(input logic [35:0] d, input logic [5:0] sh);
        longint v;
        longint r;
        int     s;
        v = longint'($signed(d));
        s = (sh > 6'd35) ? 35 : int'(sh);
        if (s == 0) r = v;
        else        r = (v + (64'sd1 <<< (s - 1))) >>> s;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(r)};
    endfunction

    // Accept one sample with out_ready high and confirm it appears exactly two edges later.
    task automatic applyStimulus(input string tag, input logic [35:0] data, input logic [5:0] shift,
                                 input logic [15:0] expData, input logic expSat);
        in_data  = data;
        in_shift = shift;
        in_valid = 1'b1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_lat2_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(out_data), 64'(expData));
        checkOutput({tag, "_sat"}, 64'(out_sat), 64'(expSat));
    endtask

    initial begin
        logic [16:0] exp17;
        logic [15:0] prevData;
        logic        prevSat;
        logic        holding;
        int          sent;
        int          received;

        reset           = 1'b1;
        in_data         = '0;
        in_shift        = '0;
        in_valid        = 1'b0;
        out_ready       = 1'b1;
        sat_count_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_sat", 64'(out_sat), 64'd0);
        checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        // Half-up rounding on small values.
        applyStimulus("rnd_p3", 36'sd3, 6'd1, 16'd2, 1'b0);
        applyStimulus("rnd_m3", -36'sd3, 6'd1, 16'hFFFF, 1'b0);
        applyStimulus("rnd_m5", -36'sd5, 6'd1, 16'hFFFE, 1'b0);
        applyStimulus("rnd_s4", 36'sd2047, 6'd4, 16'h0080, 1'b0);

        // Saturation at both rails, including overflow caused by the rounding carry.
        applyStimulus("sat_pos", 36'sd1048576, 6'd0, 16'h7FFF, 1'b1);
        applyStimulus("sat_neg", -36'sd1048576, 6'd0, 16'h8000, 1'b1);
        applyStimulus("sat_rnd", 36'sd65535, 6'd1, 16'h7FFF, 1'b1);
        applyStimulus("nosat_edge", 36'sd65533, 6'd1, 16'h7FFF, 1'b0);
        checkOutput("sat_count_3", 64'(sat_count), 64'd3);

        // Oversized shift amounts behave like a shift of 35.
        applyStimulus("clamp_neg", 36'h800000000, 6'd63, 16'hFFFF, 1'b0);
        applyStimulus("clamp_pos", 36'h7FFFFFFFF, 6'd40, 16'h0001, 1'b0);
        @(posedge clk); #1;

        // Random stream under random back-pressure, scored in order against the model.
        sent     = 0;
        received = 0;
        holding  = 1'b0;
        prevData = '0;
        prevSat  = 1'b0;
        for (int cyc = 0; cyc < 3000 && received < 100; cyc++) begin
            @(posedge clk); #1;
            if (holding) begin
                checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
                checkOutput("bp_hold_data", 64'(out_data), 64'(prevData));
                checkOutput("bp_hold_sat", 64'(out_sat), 64'(prevSat));
            end
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            in_data   = 36'({$urandom, $urandom});
            in_shift  = 6'($urandom_range(0, 63));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("bp_in_ready", 64'(in_ready), (expQ.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
            holding  = out_valid && !out_ready;
            prevData = out_data;
            prevSat  = out_sat;
            if (out_valid && out_ready) begin
                checkOutput("bp_outstanding", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    exp17 = expQ.pop_front();
                    checkOutput("bp_data", 64'({out_sat, out_data}), 64'(exp17));
                end
                received++;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refQuant(in_data, in_shift));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_all_received", 64'(received), 64'd100);
        checkOutput("bp_queue_empty", 64'(expQ.size()), 64'd0);
        @(posedge clk); #1;

        // Clear wins over an increment on the same deliver edge.
        out_ready = 1'b0;
        in_data   = 36'sd1048576;
        in_shift  = 6'd0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("clr_held_valid", 64'(out_valid), 64'd1);
        out_ready       = 1'b1;
        sat_count_clear = 1'b1;
        @(posedge clk); #1;
        sat_count_clear = 1'b0;
        checkOutput("clr_priority", 64'(sat_count), 64'd0);
        checkOutput("clr_delivered", 64'(out_valid), 64'd0);

        // Preload the counter to just below the top, then to the top, then past it.
        in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cnt_fffe", 64'(sat_count), 64'hFFFE);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cnt_ffff", 64'(sat_count), 64'hFFFF);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cnt_stick", 64'(sat_count), 64'hFFFF);

        // Fill both stages, then reset with them in flight.
        out_ready = 1'b0;
        in_data   = 36'sd1048576;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data = -36'sd1048576;
        checkOutput("mid_in_ready_half", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mid_in_ready_full", 64'(in_ready), 64'd0);
        checkOutput("mid_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_count", 64'(sat_count), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        applyStimulus("post_rst", 36'sd3, 6'd1, 16'd2, 1'b0);
        @(posedge clk); #1;
        checkOutput("post_rst_count", 64'(sat_count), 64'd0);
        checkOutput("post_rst_drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
